// File: rtl/systolic_topk_sorter_if.sv
// Stream bundle for systolic_topk_sorter: batch input and
// ordered drain output, both valid/ready.
interface systolic_topk_sorter_if #(
  parameter int KEY_WIDTH  = 32,
  parameter int META_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [KEY_WIDTH-1:0]  in_key;
  logic [META_WIDTH-1:0] in_meta;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [KEY_WIDTH-1:0]  out_key;
  logic [META_WIDTH-1:0] out_meta;
  logic                  out_last;

  modport master (
    output in_valid, in_key, in_meta, in_last, out_ready,
    input  in_ready, out_valid, out_key, out_meta, out_last
  );

  modport slave (
    input  in_valid, in_key, in_meta, in_last, out_ready,
    output in_ready, out_valid, out_key, out_meta, out_last
  );
endinterface

// File: rtl/systolic_topk_sorter.sv
// Systolic top-K insertion sorter: a chain of compare/swap cells keeps
// the best ELEMENTS keys of a batch, then drains them in order.
module systolic_topk_sorter #(
  parameter int ELEMENTS   = 64,
  parameter int KEY_WIDTH  = 32,
  parameter int META_WIDTH = 64,
  parameter bit DESCENDING = 1'b0,
  localparam int CW = $clog2(ELEMENTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  systolic_topk_sorter_if.slave bus,
  output logic [CW-1:0]         count,
  output logic [31:0]           dropped,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_FILL,
    S_FLUSH,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic [ELEMENTS-1:0]   r_cv;
  logic [ELEMENTS-1:0]   w_cv_n;
  logic [KEY_WIDTH-1:0]  r_ck   [ELEMENTS];
  logic [KEY_WIDTH-1:0]  w_ck_n [ELEMENTS];
  logic [META_WIDTH-1:0] r_cm   [ELEMENTS];
  logic [META_WIDTH-1:0] w_cm_n [ELEMENTS];

  logic [ELEMENTS-2:0]   r_mv;
  logic [KEY_WIDTH-1:0]  r_mk [ELEMENTS-1];
  logic [META_WIDTH-1:0] r_mm [ELEMENTS-1];

  logic [ELEMENTS-1:0]   w_iv;
  logic [KEY_WIDTH-1:0]  w_ik [ELEMENTS];
  logic [META_WIDTH-1:0] w_im [ELEMENTS];
  logic [ELEMENTS-1:0]   w_ev;
  logic [KEY_WIDTH-1:0]  w_ek [ELEMENTS];
  logic [META_WIDTH-1:0] w_em [ELEMENTS];

  logic [CW-1:0] r_count;
  logic [CW-1:0] r_fcnt;
  logic [31:0]   r_drop;
  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_cap;
  logic          w_drop;

  function automatic logic f_beats(
    input logic [KEY_WIDTH-1:0] a,
    input logic [KEY_WIDTH-1:0] b
  );
    return DESCENDING ? (a > b) : (a < b);
  endfunction

  // rst_n gates in_ready so nothing is offered while held in reset
  assign bus.in_ready  = rst_n && !clear && (r_state == S_FILL);
  assign w_in_fire     = bus.in_valid && bus.in_ready;
  assign bus.out_valid = !clear && (r_state == S_DRAIN) &&
                         (r_count != '0);
  assign w_out_fire    = bus.out_valid && bus.out_ready;
  assign bus.out_key   = r_ck[0];
  assign bus.out_meta  = r_cm[0];
  assign bus.out_last  = bus.out_valid && (r_count == CW'(1));

  assign count   = r_count;
  assign dropped = r_drop;
  assign busy    = (r_state != S_FILL);
  assign w_drop  = w_ev[ELEMENTS-1];

  always_comb begin
    w_iv[0] = w_in_fire;
    w_ik[0] = bus.in_key;
    w_im[0] = bus.in_meta;
    for (int i = 1; i < ELEMENTS; i++) begin
      w_iv[i] = r_mv[i-1];
      w_ik[i] = r_mk[i-1];
      w_im[i] = r_mm[i-1];
    end
  end

  always_comb begin
    w_cv_n = r_cv;
    w_ev   = '0;
    w_cap  = 1'b0;
    for (int i = 0; i < ELEMENTS; i++) begin
      w_ck_n[i] = r_ck[i];
      w_cm_n[i] = r_cm[i];
      w_ek[i]   = w_ik[i];
      w_em[i]   = w_im[i];
    end
    if (w_out_fire) begin
      for (int i = 0; i < ELEMENTS - 1; i++) begin
        w_cv_n[i] = r_cv[i+1];
        w_ck_n[i] = r_ck[i+1];
        w_cm_n[i] = r_cm[i+1];
      end
      w_cv_n[ELEMENTS-1] = 1'b0;
    end else if (r_state != S_DRAIN) begin
      for (int i = 0; i < ELEMENTS; i++) begin
        if (!r_cv[i]) begin
          if (w_iv[i]) begin
            w_cv_n[i] = 1'b1;
            w_ck_n[i] = w_ik[i];
            w_cm_n[i] = w_im[i];
            w_cap     = 1'b1;
          end
        end else if (w_iv[i]) begin
          w_ev[i] = 1'b1;
          // strict compare: equal keys never swap, preserving arrival order
          if (f_beats(w_ik[i], r_ck[i])) begin
            w_ck_n[i] = w_ik[i];
            w_cm_n[i] = w_im[i];
            w_ek[i]   = r_ck[i];
            w_em[i]   = r_cm[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cv    <= '0;
      r_mv    <= '0;
      r_count <= '0;
      r_fcnt  <= '0;
      r_drop  <= '0;
    end else if (clear) begin
      r_cv    <= '0;
      r_mv    <= '0;
      r_count <= '0;
      r_fcnt  <= '0;
      r_drop  <= '0;
    end else begin
      r_cv <= w_cv_n;
      r_mv <= w_ev[ELEMENTS-2:0];
      if (w_out_fire)
        r_count <= r_count - CW'(1);
      else if (w_cap && (r_count != CW'(ELEMENTS)))
        r_count <= r_count + CW'(1);
      if (w_drop && (r_drop != '1))
        r_drop <= r_drop + 32'd1;
      r_fcnt <= (r_state == S_FLUSH) ? r_fcnt + CW'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ELEMENTS; i++) begin
      r_ck[i] <= w_ck_n[i];
      r_cm[i] <= w_cm_n[i];
    end
    for (int i = 0; i < ELEMENTS - 1; i++) begin
      r_mk[i] <= w_ek[i];
      r_mm[i] <= w_em[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FILL;
    else        r_state <= w_state_n;
  end

  // FLUSH lasts ELEMENTS cycles so the last arrival has crossed every cell
  always_comb begin
    w_state_n = r_state;
    if (clear) begin
      w_state_n = S_FILL;
    end else begin
      unique case (r_state)
        S_FILL:
          if (w_in_fire && bus.in_last)
            w_state_n = S_FLUSH;
        S_FLUSH:
          if (r_fcnt == CW'(ELEMENTS - 1))
            w_state_n = S_DRAIN;
        S_DRAIN:
          if ((r_count == '0) || (w_out_fire && bus.out_last))
            w_state_n = S_FILL;
        default:
          w_state_n = S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_topk_sorter.sv
// Directed bench for systolic_topk_sorter: ascending and descending
// instances, ELEMENTS=4, hand-computed expectations.
module tb_systolic_topk_sorter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  systolic_topk_sorter_if #(.KEY_WIDTH(16), .META_WIDTH(8)) bus_a ();
  systolic_topk_sorter_if #(.KEY_WIDTH(16), .META_WIDTH(8)) bus_d ();

  logic [2:0]  cnt_a, cnt_d;
  logic [31:0] drp_a, drp_d;
  logic        busy_a, busy_d;

  systolic_topk_sorter #(
    .ELEMENTS(4), .KEY_WIDTH(16), .META_WIDTH(8), .DESCENDING(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_a),
    .count(cnt_a), .dropped(drp_a), .busy(busy_a)
  );

  systolic_topk_sorter #(
    .ELEMENTS(4), .KEY_WIDTH(16), .META_WIDTH(8), .DESCENDING(1'b1)
  ) dut_d (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_d),
    .count(cnt_d), .dropped(drp_d), .busy(busy_d)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive_in(input bit sel, input logic v,
                          input logic [15:0] k, input logic [7:0] m,
                          input logic l);
    if (sel) begin
      bus_d.in_valid = v; bus_d.in_key = k;
      bus_d.in_meta  = m; bus_d.in_last = l;
    end else begin
      bus_a.in_valid = v; bus_a.in_key = k;
      bus_a.in_meta  = m; bus_a.in_last = l;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus_d.in_ready : bus_a.in_ready;
  endfunction
  function automatic logic ovld(input bit sel);
    return sel ? bus_d.out_valid : bus_a.out_valid;
  endfunction
  function automatic logic [15:0] okey(input bit sel);
    return sel ? bus_d.out_key : bus_a.out_key;
  endfunction
  function automatic logic [7:0] ometa(input bit sel);
    return sel ? bus_d.out_meta : bus_a.out_meta;
  endfunction
  function automatic logic olast(input bit sel);
    return sel ? bus_d.out_last : bus_a.out_last;
  endfunction
  function automatic logic [2:0] ocnt(input bit sel);
    return sel ? cnt_d : cnt_a;
  endfunction

  task automatic send(input bit sel, input logic [15:0] k,
                      input logic [7:0] m, input logic l);
    int n = 0;
    @(negedge clk);
    drive_in(sel, 1'b1, k, m, l);
    #1;
    while (!rdy(sel) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("in_ready_wait", rdy(sel), 1'b1);
    @(posedge clk);
  endtask

  task automatic idle(input bit sel);
    @(negedge clk);
    drive_in(sel, 1'b0, '0, '0, 1'b0);
    #1;
  endtask

  task automatic drain_one(input bit sel, input logic [15:0] k,
                           input logic [7:0] m, input logic l,
                           input logic [2:0] c, output int waits);
    int n = 0;
    @(negedge clk);
    if (sel) bus_d.out_ready = 1'b1;
    else     bus_a.out_ready = 1'b1;
    #1;
    while (!ovld(sel) && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk("out_valid", ovld(sel), 1'b1);
    chk("out_key", okey(sel), k);
    chk("out_meta", ometa(sel), m);
    chk("out_last", olast(sel), l);
    chk("out_count", ocnt(sel), c);
    waits = n;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int w;
    drive_in(1'b0, 1'b0, '0, '0, 1'b0);
    drive_in(1'b1, 1'b0, '0, '0, 1'b0);
    bus_a.out_ready = 1'b0;
    bus_d.out_ready = 1'b0;
    #2;
    chk("rst_in_ready", bus_a.in_ready, 1'b0);
    chk("rst_out_valid", bus_a.out_valid, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_count", cnt_a, 3'd0);
    chk("rst_dropped", drp_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", bus_a.in_ready, 1'b1);

    // 7,3,9,1 -> 1,3,7,9
    send(0, 16'd7, 8'h07, 0); send(0, 16'd3, 8'h03, 0);
    send(0, 16'd9, 8'h09, 0); send(0, 16'd1, 8'h01, 1);
    idle(0);
    chk("b1_busy", busy_a, 1'b1);
    chk("b1_in_ready_flush", bus_a.in_ready, 1'b0);
    chk("b1_out_valid_flush", bus_a.out_valid, 1'b0);
    // first FLUSH cycle is the idle step, three more follow
    drain_one(0, 16'd1, 8'h01, 0, 3'd4, w);
    chk("b1_flush_len", w, 3);
    drain_one(0, 16'd3, 8'h03, 0, 3'd3, w);
    drain_one(0, 16'd7, 8'h07, 0, 3'd2, w);
    drain_one(0, 16'd9, 8'h09, 1, 3'd1, w);
    chk("b1_consecutive", w, 0);
    @(negedge clk); #1;
    chk("b1_end_busy", busy_a, 1'b0);
    chk("b1_end_count", cnt_a, 3'd0);
    chk("b1_end_dropped", drp_a, 32'd0);
    chk("b1_end_in_ready", bus_a.in_ready, 1'b1);

    // 5,8,2,6,1,9 -> 1,2,5,6, two dropped
    send(0, 16'd5, 8'h05, 0); send(0, 16'd8, 8'h08, 0);
    send(0, 16'd2, 8'h02, 0); send(0, 16'd6, 8'h06, 0);
    send(0, 16'd1, 8'h01, 0); send(0, 16'd9, 8'h09, 1);
    idle(0);
    drain_one(0, 16'd1, 8'h01, 0, 3'd4, w);
    drain_one(0, 16'd2, 8'h02, 0, 3'd3, w);
    drain_one(0, 16'd5, 8'h05, 0, 3'd2, w);
    drain_one(0, 16'd6, 8'h06, 1, 3'd1, w);
    @(negedge clk); #1;
    chk("b2_dropped", drp_a, 32'd2);
    chk("b2_end_count", cnt_a, 3'd0);

    // equal keys keep arrival order; stall holds outputs
    send(0, 16'd4, 8'h0A, 0); send(0, 16'd4, 8'h0B, 0);
    send(0, 16'd4, 8'h0C, 1);
    idle(0);
    drain_one(0, 16'd4, 8'h0A, 0, 3'd3, w);
    @(negedge clk);
    bus_a.out_ready = 1'b0;
    #1;
    chk("stall1_valid", bus_a.out_valid, 1'b1);
    chk("stall1_meta", bus_a.out_meta, 8'h0B);
    chk("stall1_last", bus_a.out_last, 1'b0);
    @(negedge clk); #1;
    chk("stall2_key", bus_a.out_key, 16'd4);
    chk("stall2_meta", bus_a.out_meta, 8'h0B);
    chk("stall2_count", cnt_a, 3'd2);
    drain_one(0, 16'd4, 8'h0B, 0, 3'd2, w);
    drain_one(0, 16'd4, 8'h0C, 1, 3'd1, w);
    @(negedge clk); #1;
    chk("b3_dropped_kept", drp_a, 32'd2);

    // clear during DRAIN
    send(0, 16'd7, 8'h07, 0); send(0, 16'd3, 8'h03, 1);
    idle(0);
    drain_one(0, 16'd3, 8'h03, 0, 3'd2, w);
    @(negedge clk);
    clear = 1'b1;
    #1;
    chk("clr_out_valid", bus_a.out_valid, 1'b0);
    chk("clr_in_ready", bus_a.in_ready, 1'b0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("post_clr_out_valid", bus_a.out_valid, 1'b0);
    chk("post_clr_count", cnt_a, 3'd0);
    chk("post_clr_dropped", drp_a, 32'd0);
    chk("post_clr_in_ready", bus_a.in_ready, 1'b1);
    chk("post_clr_busy", busy_a, 1'b0);
    send(0, 16'd2, 8'h02, 1);
    idle(0);
    drain_one(0, 16'd2, 8'h02, 1, 3'd1, w);
    chk("single_flush_len", w, 3);

    // async reset mid-FLUSH
    send(0, 16'd6, 8'h06, 0); send(0, 16'd2, 8'h02, 0);
    send(0, 16'd8, 8'h08, 1);
    idle(0);
    chk("b5_busy", busy_a, 1'b1);
    chk("b5_count", cnt_a, 3'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy_a, 1'b0);
    chk("mrst_count", cnt_a, 3'd0);
    chk("mrst_in_ready", bus_a.in_ready, 1'b0);
    chk("mrst_out_valid", bus_a.out_valid, 1'b0);
    chk("mrst_out_last", bus_a.out_last, 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("mrst_rel_in_ready", bus_a.in_ready, 1'b1);
    send(0, 16'd5, 8'h05, 0); send(0, 16'd1, 8'h01, 0);
    send(0, 16'd3, 8'h03, 0); send(0, 16'd2, 8'h02, 1);
    idle(0);
    drain_one(0, 16'd1, 8'h01, 0, 3'd4, w);
    drain_one(0, 16'd2, 8'h02, 0, 3'd3, w);
    drain_one(0, 16'd3, 8'h03, 0, 3'd2, w);
    drain_one(0, 16'd5, 8'h05, 1, 3'd1, w);

    // descending instance: 5,8,2,6,1,9 -> 9,8,6,5
    send(1, 16'd5, 8'h05, 0); send(1, 16'd8, 8'h08, 0);
    send(1, 16'd2, 8'h02, 0); send(1, 16'd6, 8'h06, 0);
    send(1, 16'd1, 8'h01, 0); send(1, 16'd9, 8'h09, 1);
    idle(1);
    drain_one(1, 16'd9, 8'h09, 0, 3'd4, w);
    drain_one(1, 16'd8, 8'h08, 0, 3'd3, w);
    drain_one(1, 16'd6, 8'h06, 0, 3'd2, w);
    drain_one(1, 16'd5, 8'h05, 1, 3'd1, w);
    @(negedge clk); #1;
    chk("desc_dropped", drp_d, 32'd2);
    chk("desc_end_busy", busy_d, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/systolic_topk_sorter.md
SYSTOLIC_TOPK_SORTER -- requirements
Module: systolic_topk_sorter

Interface
REQ-001 SHALL have parameter ELEMENTS, default 64, number of sort cells (power of two not required, >=2).
REQ-002 SHALL have parameter KEY_WIDTH, default 32, sort-key width in bits.
REQ-003 SHALL have parameter META_WIDTH, default 64, width of opaque metadata carried with each key.
REQ-004 SHALL have parameter DESCENDING, default 0: 0 keeps the smallest keys in ascending order, 1 keeps the largest keys in descending order.
REQ-005 SHALL have clk, input, 1, sole clock, all state on rising edge.
REQ-006 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have clear, input, 1, synchronous soft clear.
REQ-008 SHALL have in_valid/in_ready, input/output, 1 each, input handshake.
REQ-009 SHALL have in_key (KEY_WIDTH), in_meta (META_WIDTH), in_last (1), inputs, element and end-of-batch marker.
REQ-010 SHALL have out_valid/out_ready, output/input, 1 each, drain handshake.
REQ-011 SHALL have out_key (KEY_WIDTH), out_meta (META_WIDTH), out_last (1), outputs, drained element and final-element flag.
REQ-012 SHALL have count, output, $clog2(ELEMENTS+1), number of occupied cells.
REQ-013 SHALL have dropped, output, 32, saturating count of elements discarded off the array end.
REQ-014 SHALL have busy, output, 1, high in FLUSH or DRAIN.

Function
REQ-015 SHALL implement states FILL, FLUSH, DRAIN; busy = (state != FILL).
REQ-016 SHALL assert in_ready only in FILL with clear low; a transfer occurs when in_valid and in_ready are both high.
REQ-017 SHALL present each accepted element to cell 0 the same cycle; each cell i per cycle: if empty, capture incoming and emit nothing; if incoming invalid, pass invalid; else if incoming beats stored (key < stored for DESCENDING=0, key > stored for 1), swap and emit old stored; else emit incoming unchanged.
REQ-018 SHALL keep equal keys in arrival order (no swap on equality).
REQ-019 SHALL discard any valid element leaving cell ELEMENTS-1 and increment dropped, saturating at 2^32-1.
REQ-020 SHALL increment count when an element is captured by an empty cell, saturating at ELEMENTS; count never exceeds ELEMENTS.
REQ-021 SHALL move FILL->FLUSH on the cycle after a transfer with in_last=1.
REQ-022 SHALL remain in FLUSH exactly ELEMENTS cycles, then enter DRAIN; no input is accepted in FLUSH.
REQ-023 SHALL, in DRAIN, drive out_valid=1 and present cell 0 on out_key/out_meta, with out_last=1 when count==1.
REQ-024 SHALL, on an out_valid&&out_ready transfer, shift every cell i+1 into cell i, invalidate cell ELEMENTS-1, and decrement count.
REQ-025 SHALL hold out_key/out_meta/out_last stable while out_valid=1 and out_ready=0.
REQ-026 SHALL return DRAIN->FILL the cycle after the out_last transfer, with all cells empty and count=0; dropped is retained.
REQ-027 SHALL treat count==0 on DRAIN entry (impossible per REQ-021) by going to FILL with out_valid never asserted.
REQ-028 SHALL, on clear=1 in any state, at the next edge empty all cells and moving stages, zero count and dropped, enter FILL; clear overrides a simultaneous input or output handshake (neither counts as a transfer, in_ready=0 and out_valid=0 that cycle).
REQ-029 SHALL keep out_valid=0 outside DRAIN.

Reset
REQ-030 SHALL, while rst_n=0, immediately force state=FILL, all cell and moving valid bits 0, count=0, dropped=0, out_valid=0, out_last=0, busy=0, in_ready=0.
REQ-031 SHALL, after rst_n rises, assert in_ready from the first rising edge; reset mid-FLUSH or mid-DRAIN discards all contents.
REQ-032 SHALL leave key/metadata storage unreset; only valid state is reset.

Verification (ELEMENTS=4, DESCENDING=0 unless stated)
REQ-033 Keys 7,3,9,1(last), out_ready=1 -> FLUSH 4 cycles, then out 1,3,7,9 on consecutive cycles, out_last on 9, dropped=0, count 4->0.
REQ-034 Keys 5,8,2,6,1,9(last) -> out 1,2,5,6, dropped=2, count max 4.
REQ-035 DESCENDING=1, keys 5,8,2,6,1,9(last) -> out 9,8,6,5.
REQ-036 Keys 4(meta A),4(meta B),4(meta C, last) -> out metas A,B,C; out_ready toggled 1,0,0,1 -> outputs held stable while stalled.
REQ-037 clear pulsed during DRAIN after first output -> next cycle out_valid=0, count=0, dropped=0, in_ready=1; new batch 2(last) drains as single element with out_last=1.
REQ-038 rst_n asserted mid-FLUSH -> outputs take reset values without clock edge; subsequent batch sorts correctly.
